// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Main control FSM for the multi-cycle femtoRV32 datapath. It sequences
// fetch / decode / execute / memory / write-back for R-type, LW, SW and BEQ,
// drives every datapath mux select and enable, runs a req/ack memory
// handshake and keeps a retired-instruction counter for debug.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous, active-low reset
//   Inst      in  32  instruction register contents
//   zero      in   1  ALU zero flag (branch taken when set in BRANCH)
//   mem_ack   in   1  memory completion, looked at only in FETCH/MEM_RD/MEM_WR
//   ALUOp     out  2  00 add, 01 subtract, 10 decode funct3/funct7
//   ALUSrcA   out  1  0 = PC, 1 = rs1
//   ALUSrcB   out  2  00 = rs2, 01 = constant 4, 10 = immediate
//   IorD      out  1  memory address: 0 = PC, 1 = ALU result
//   mem_req   out  1  memory request
//   mem_we    out  1  memory write enable (qualified by mem_req)
//   IRWrite   out  1  load instruction register
//   PCWrite   out  1  load PC
//   PCSrc     out  1  0 = ALU result (PC+4), 1 = branch-target adder
//   RegWrite  out  1  register-file write
//   MemtoReg  out  1  write-back source: 0 = ALU, 1 = memory data
//   illegal   out  1  one-cycle pulse on an unsupported opcode
//   retired   out 32  count of completed instructions (wraps)
//   state     out  4  current state encoding, for debug
// -----------------------------------------------------------------------------
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Inst,
  input  logic        zero,
  input  logic        mem_ack,
  output logic [1:0]  ALUOp,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic        IorD,
  output logic        mem_req,
  output logic        mem_we,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        illegal,
  output logic [31:0] retired,
  output logic [3:0]  state
);

  // State encodings are visible on the debug port, so they are fixed values.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  // Opcodes handled by this datapath.
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU operation classes understood by the ALU control decoder.
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // ALU B-operand selects.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] retired_q;
  logic        retire_en;
  logic [6:0]  opcode;

  assign opcode = Inst[6:0];

  // Only the opcode field steers the sequence; the rest of the instruction
  // word belongs to the datapath and the ALU control decoder.
  logic unused_inst_bits;
  assign unused_inst_bits = ^Inst[31:7];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge; blocking here would create ordering races
  // with any other clocked process reading state_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so that every path assigns
  // it; a missing assignment on any branch would infer a latch.
  always_comb begin
    state_d = S_IDLE;
    unique case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    state_d = mem_ack ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (opcode)
          OP_RTYPE:           state_d = S_EXEC_R;
          OP_LOAD, OP_STORE:  state_d = S_MEM_ADDR;
          OP_BRANCH:          state_d = S_BRANCH;
          default:            state_d = S_FETCH;   // illegal: refetch
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_WB_R:     state_d = S_FETCH;
      // Inst[5] is the only bit separating LW (0000011) from SW (0100011).
      S_MEM_ADDR: state_d = Inst[5] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = mem_ack ? S_WB_MEM : S_MEM_RD;
      S_WB_MEM:   state_d = S_FETCH;
      S_MEM_WR:   state_d = mem_ack ? S_FETCH : S_MEM_WR;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_IDLE;                // encodings 10..15 recover
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  // Mostly Moore decode of state_q. IRWrite/PCWrite in FETCH follow mem_ack,
  // PCWrite in BRANCH follows zero, and illegal depends on the opcode in
  // DECODE; these are the only input-dependent terms.
  always_comb begin
    ALUOp     = ALU_ADD;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_RS2;
    IorD      = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = 1'b0;
    RegWrite  = 1'b0;
    MemtoReg  = 1'b0;
    illegal   = 1'b0;
    retire_en = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        // ALU computes PC+4 while memory returns the instruction.
        mem_req = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ack;
        PCWrite = mem_ack;
      end
      S_DECODE: begin
        illegal = !(opcode == OP_RTYPE || opcode == OP_LOAD ||
                    opcode == OP_STORE || opcode == OP_BRANCH);
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_WB_R: begin
        // ALU controls held so the result is still valid at write-back.
        ALUSrcA   = 1'b1;
        ALUOp     = ALU_FUNCT;
        RegWrite  = 1'b1;
        retire_en = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        mem_req = 1'b1;
        IorD    = 1'b1;
      end
      S_WB_MEM: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        retire_en = 1'b1;
      end
      S_MEM_WR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        IorD      = 1'b1;
        retire_en = mem_ack;
      end
      S_BRANCH: begin
        // Subtract sets zero on equality; the target comes from a separate
        // adder, so PCSrc is asserted regardless of the outcome.
        ALUSrcA   = 1'b1;
        ALUOp     = ALU_SUB;
        PCSrc     = 1'b1;
        PCWrite   = zero;
        retire_en = 1'b1;
      end
      default: ;                                   // IDLE and unused: all 0
    endcase
  end

  // ---------------------------------------------------------------------------
  // Retired-instruction counter (free-running modulo 2^32)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_q <= '0;
    end else if (retire_en) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed bench for multicycle_control. Each instruction is stepped from
// FETCH back to FETCH with a chosen mem_ack delay; per-cycle outputs are
// recorded into a trace and compared against hand-derived values.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

  logic        clk;
  logic        rst;
  logic [31:0] Inst;
  logic        zero;
  logic        mem_ack;
  logic [1:0]  ALUOp;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        IorD;
  logic        mem_req;
  logic        mem_we;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCSrc;
  logic        RegWrite;
  logic        MemtoReg;
  logic        illegal;
  logic [31:0] retired;
  logic [3:0]  state;

  multicycle_control dut (
    .clk      (clk),
    .rst      (rst),
    .Inst     (Inst),
    .zero     (zero),
    .mem_ack  (mem_ack),
    .ALUOp    (ALUOp),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .IorD     (IorD),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .IRWrite  (IRWrite),
    .PCWrite  (PCWrite),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemtoReg (MemtoReg),
    .illegal  (illegal),
    .retired  (retired),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_RTYPE = 32'h0020_81B3;  // add x3,x1,x2
  localparam logic [31:0] I_LW    = 32'h0000_A183;  // lw  x3,0(x1)
  localparam logic [31:0] I_SW    = 32'h0030_A223;  // sw  x3,4(x1)
  localparam logic [31:0] I_BEQ   = 32'h0020_8463;  // beq x1,x2,+8
  localparam logic [31:0] I_ILL   = 32'h0000_007F;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       iord;
    logic       req;
    logic       we;
    logic       irw;
    logic       pcw;
    logic       pcsrc;
    logic       regw;
    logic       m2r;
    logic       ill;
  } rec_t;

  rec_t trace [0:31];
  int   n_trace;
  int   cnt_req, cnt_irw, cnt_pcw, cnt_regw, cnt_we, cnt_ill;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  // Run one instruction starting in FETCH until the FSM returns to FETCH.
  // Request states see mem_ack only after ack_delay waiting cycles; all
  // other states see mem_ack=1, which the FSM must ignore.
  task automatic run_instr(input logic [31:0] inst, input int ack_delay,
                           input logic z);
    int       wait_n;
    logic [3:0] prev;
    bit       done;
    Inst     = inst;
    zero     = z;
    n_trace  = 0;
    cnt_req  = 0; cnt_irw = 0; cnt_pcw = 0;
    cnt_regw = 0; cnt_we  = 0; cnt_ill = 0;
    wait_n   = 0;
    prev     = 4'hF;
    done     = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (state != prev) wait_n = 0;
      prev = state;
      if (state == 4'd1 || state == 4'd6 || state == 4'd8)
        mem_ack = (wait_n == ack_delay);
      else
        mem_ack = 1'b1;
      wait_n++;
      #1;
      trace[n_trace] = '{st: state, aluop: ALUOp, srca: ALUSrcA,
                         srcb: ALUSrcB, iord: IorD, req: mem_req,
                         we: mem_we, irw: IRWrite, pcw: PCWrite,
                         pcsrc: PCSrc, regw: RegWrite, m2r: MemtoReg,
                         ill: illegal};
      cnt_req  += int'(mem_req);
      cnt_irw  += int'(IRWrite);
      cnt_pcw  += int'(PCWrite);
      cnt_regw += int'(RegWrite);
      cnt_we   += int'(mem_we);
      cnt_ill  += int'(illegal);
      n_trace++;
      cyc();
      if (state == 4'd1 && trace[n_trace-1].st != 4'd1) done = 1'b1;
    end
    if (!done) check("return_to_fetch_timeout", 32'd0, 32'd1);
  endtask

  logic [3:0] lw_seq [0:10] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd5,
                                4'd6, 4'd6, 4'd6, 4'd6, 4'd7};
  logic [3:0] r_seq  [0:3]  = '{4'd1, 4'd2, 4'd3, 4'd4};
  logic [3:0] sw_seq [0:3]  = '{4'd1, 4'd2, 4'd5, 4'd8};

  initial begin
    rst     = 1'b0;
    Inst    = 32'h0;
    zero    = 1'b0;
    mem_ack = 1'b0;

    // ---------------- reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_state",   {28'd0, state}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    Inst    = I_RTYPE;
    mem_ack = 1'b1;
    rst     = 1'b1;
    cyc();
    check("first_edge_fetch", {28'd0, state}, 32'd1);

    // ---------------- R-type, mem_ack tied high
    run_instr(I_RTYPE, 0, 1'b0);
    check("r_len", n_trace, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("r_state%0d", i), {28'd0, trace[i].st}, {28'd0, r_seq[i]});
    check("r_fetch_srcb",   {30'd0, trace[0].srcb}, 32'd1);
    check("r_fetch_irw",    {31'd0, trace[0].irw}, 32'd1);
    check("r_exec_aluop",   {30'd0, trace[2].aluop}, 32'd2);
    check("r_exec_srca",    {31'd0, trace[2].srca}, 32'd1);
    check("r_wb_aluop",     {30'd0, trace[3].aluop}, 32'd2);
    check("r_wb_regwrite",  {31'd0, trace[3].regw}, 32'd1);
    check("r_regwrite_cnt", cnt_regw, 1);
    check("r_retired",      retired, 32'd1);

    // ---------------- LW with 3-cycle ack delay in FETCH and MEM_RD
    run_instr(I_LW, 3, 1'b0);
    check("lw_len", n_trace, 11);
    for (int i = 0; i < 11; i++)
      check($sformatf("lw_state%0d", i), {28'd0, trace[i].st}, {28'd0, lw_seq[i]});
    check("lw_req_cnt",     cnt_req, 8);
    check("lw_fetch_req_last", {31'd0, trace[3].req}, 32'd1);
    check("lw_rd_req_last", {31'd0, trace[9].req}, 32'd1);
    check("lw_rd_iord",     {31'd0, trace[6].iord}, 32'd1);
    check("lw_irw_cnt",     cnt_irw, 1);
    check("lw_pcw_cnt",     cnt_pcw, 1);
    check("lw_irw_at_ack",  {31'd0, trace[3].irw}, 32'd1);
    check("lw_wb_m2r",      {31'd0, trace[10].m2r}, 32'd1);
    check("lw_wb_regw",     {31'd0, trace[10].regw}, 32'd1);
    check("lw_retired",     retired, 32'd2);

    // ---------------- BEQ taken
    run_instr(I_BEQ, 0, 1'b1);
    check("beq1_len",    n_trace, 3);
    check("beq1_state",  {28'd0, trace[2].st}, 32'd9);
    check("beq1_aluop",  {30'd0, trace[2].aluop}, 32'd1);
    check("beq1_pcsrc",  {31'd0, trace[2].pcsrc}, 32'd1);
    check("beq1_pcw",    {31'd0, trace[2].pcw}, 32'd1);
    check("beq1_retired", retired, 32'd3);

    // ---------------- BEQ not taken
    run_instr(I_BEQ, 0, 1'b0);
    check("beq0_len",    n_trace, 3);
    check("beq0_aluop",  {30'd0, trace[2].aluop}, 32'd1);
    check("beq0_pcsrc",  {31'd0, trace[2].pcsrc}, 32'd1);
    check("beq0_pcw",    {31'd0, trace[2].pcw}, 32'd0);
    check("beq0_retired", retired, 32'd4);

    // ---------------- reset in MEM_RD of a load
    Inst    = I_LW;
    mem_ack = 1'b1;
    cyc();                                   // DECODE
    cyc();                                   // MEM_ADDR
    mem_ack = 1'b0;
    cyc();                                   // MEM_RD, stalled
    #1;
    check("mid_lw_state",   {28'd0, state}, 32'd6);
    check("mid_lw_req",     {31'd0, mem_req}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_state",   {28'd0, state}, 32'd0);
    check("mid_rst_req",     {31'd0, mem_req}, 32'd0);
    check("mid_rst_retired", retired, 32'd0);
    rst = 1'b1;
    cyc();
    check("mid_rst_fetch",   {28'd0, state}, 32'd1);

    // ---------------- SW
    run_instr(I_SW, 0, 1'b0);
    check("sw_len", n_trace, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("sw_state%0d", i), {28'd0, trace[i].st}, {28'd0, sw_seq[i]});
    check("sw_we_cnt",   cnt_we, 1);
    check("sw_we_wr",    {31'd0, trace[3].we}, 32'd1);
    check("sw_iord_wr",  {31'd0, trace[3].iord}, 32'd1);
    check("sw_retired",  retired, 32'd1);

    // ---------------- illegal opcode
    run_instr(I_ILL, 0, 1'b0);
    check("ill_len",     n_trace, 2);
    check("ill_cnt",     cnt_ill, 1);
    check("ill_decode",  {31'd0, trace[1].ill}, 32'd1);
    check("ill_retired", retired, 32'd1);

    // ---------------- counter wrap
    dut.retired_q = 32'hFFFF_FFFF;
    #1;
    check("wrap_preload", retired, 32'hFFFF_FFFF);
    run_instr(I_RTYPE, 0, 1'b0);
    check("wrap_retired", retired, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle femtoRV32 datapath. It sequences fetch, decode, execute, memory and write-back for R-type, LW, SW and BEQ. It drives the 2-bit ALUOp that the ALU control decoder consumes, along with every datapath mux/enable and a req/ack memory handshake. It also keeps a retired-instruction counter for debug and verification.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Inst  in  32  instruction register contents; stable except in the cycle after IRWrite
- zero  in  1  ALU zero flag
- mem_ack  in  1  memory completion; sampled only in FETCH, MEM_RD, MEM_WR
- ALUOp  out  2  00 add, 01 subtract (branch compare), 10 use funct3/funct7
- ALUSrcA  out  1  0 = PC, 1 = rs1
- ALUSrcB  out  2  00 = rs2, 01 = constant 4, 10 = immediate
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable, valid with mem_req
- IRWrite  out  1  load instruction register
- PCWrite  out  1  load PC
- PCSrc  out  1  PC source: 0 = ALU result (PC+4), 1 = external branch-target adder
- RegWrite  out  1  register-file write
- MemtoReg  out  1  write-back source: 0 = ALU result, 1 = memory data
- illegal  out  1  one-cycle pulse on an unsupported opcode
- retired  out  32  count of completed instructions
- state  out  4  current state encoding, for debug

## Operation
- Moore outputs decode from the state register, except IRWrite, PCWrite and retired increment. Those three are Mealy terms qualified by mem_ack or zero as listed below.
- Every output not listed for a state is 0.
- State encodings and behaviour:
  - IDLE = 0: all outputs 0. Next state is FETCH.
  - FETCH = 1: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00. If mem_ack: IRWrite=1, PCWrite=1, PCSrc=0, next DECODE. Otherwise stay.
  - DECODE = 2: dispatch on Inst[6:0].
    - 0110011 goes to EXEC_R.
    - 0000011 and 0100011 go to MEM_ADDR.
    - 1100011 goes to BRANCH.
    - Any other opcode: illegal=1 for this cycle, next FETCH, retired unchanged.
  - EXEC_R = 3: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next WB_R.
  - WB_R = 4: same ALU controls as EXEC_R, RegWrite=1, MemtoReg=0. retired increments. Next FETCH.
  - MEM_ADDR = 5: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next MEM_RD if Inst[5]=0, MEM_WR if Inst[5]=1.
  - MEM_RD = 6: MEM_ADDR ALU controls, mem_req=1, IorD=1. If mem_ack, next WB_MEM; otherwise stay.
  - WB_MEM = 7: RegWrite=1, MemtoReg=1. retired increments. Next FETCH.
  - MEM_WR = 8: MEM_ADDR ALU controls, mem_req=1, mem_we=1, IorD=1. If mem_ack: retired increments, next FETCH. Otherwise stay.
  - BRANCH = 9: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=1, PCWrite=zero. retired increments. Next FETCH.
- Unused encodings 10–15 go to IDLE on the next clock, with all outputs 0.
- retired is a 32-bit unsigned counter that wraps from 0xFFFFFFFF to 0.

## Timing
- Reset: rst=0 immediately forces state=IDLE, retired=0 and all outputs 0, mid-instruction included. No memory transaction is completed.
- After rst deasserts, the first rising edge enters FETCH.
- Handshake:
  - mem_req stays high continuously until the cycle in which mem_ack=1, inclusive.
  - mem_req drops on the following edge, unless the next state issues a new request.
  - mem_ack in any state other than FETCH, MEM_RD or MEM_WR is ignored.
- Latency with mem_ack in the first request cycle, counted from FETCH entry to return to FETCH:
  - R-type: 4 cycles
  - LW: 5 cycles
  - SW: 4 cycles
  - BEQ: 3 cycles
  - Illegal opcode: 2 cycles
- Each cycle of mem_ack delay adds one cycle.
- retired updates on the rising edge that leaves the final state of the instruction.

## Test plan
- Reset mid-LW:
  - Stimulus: drop rst while in MEM_RD with mem_req=1.
  - Required: state=0, mem_req=0, retired=0 immediately. After rst release, FETCH on the next edge.
- R-type with Inst=0x002081B3 and mem_ack tied 1:
  - Required state sequence: 1,2,3,4,1.
  - ALUOp=10 in EXEC_R and WB_R.
  - RegWrite=1 only in WB_R.
  - retired goes 0→1.
- LW (0x0000A183) with mem_ack delayed 3 cycles in both FETCH and MEM_RD:
  - mem_req is held 4 cycles each time.
  - IRWrite=PCWrite=1 in exactly one cycle.
  - WB_MEM asserts MemtoReg=1 and RegWrite=1.
  - Total 11 cycles.
- BEQ (0x00208463), once with zero=1 and once with zero=0:
  - ALUOp=01 and PCSrc=1 in BRANCH in both runs.
  - zero=1: PCWrite=1.
  - zero=0: PCWrite=0.
- SW then illegal opcode 0x0000007F:
  - SW: mem_we=1 only in MEM_WR.
  - Illegal opcode: illegal=1 for exactly one cycle, return to FETCH, retired stays at 1.
- Wrap:
  - Stimulus: force retired=0xFFFFFFFF, then run one R-type.
  - Required: retired=0.
